// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 30-bit LFSR stream
// (x^30 + x^6 + x^4 + x^1). It seeds itself from the incoming bits,
// verifies its predictions, then runs as a flywheel while it reports bit errors.
module lfsr_checker #(
    parameter int LOCK_COUNT = 16,
    parameter int ERR_LIMIT  = 4,
    parameter int WINDOW     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        err_clr,
    output logic        lock,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        SEED   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_e;

    localparam logic [7:0]  LOCK_C = 8'(LOCK_COUNT);
    localparam logic [7:0]  ERR_C  = 8'(ERR_LIMIT);
    localparam logic [15:0] WIN_C  = 16'(WINDOW);

    state_e      state_q, state_d;
    logic [29:0] s_q, s_d;
    logic [4:0]  fill_q, fill_d;
    logic [7:0]  match_q, match_d;
    logic [15:0] win_q, win_d;
    logic [7:0]  bad_q, bad_d;
    logic        lock_q, lock_d;
    logic        pulse_q, pulse_d;
    logic [15:0] cnt_q, cnt_d;

    logic        pred;
    logic        err;
    logic [15:0] win_inc;
    logic [7:0]  bad_inc;

    assign pred = s_q[29] ^ s_q[5] ^ s_q[3] ^ s_q[0];

    // Next-state logic: seeding, verification and flywheel tracking with error accounting
    always_comb begin
        s_d     = s_q;
        state_d = state_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        bad_d   = bad_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        err     = 1'b0;
        win_inc = win_q + 16'd1;
        bad_inc = bad_q;
        if (bit_valid) begin
            unique case (state_q)
                SEED: begin
                    s_d = {s_q[28:0], bit_in};
                    if (fill_q == 5'd29) begin
                        state_d = VERIFY;
                        fill_d  = 5'd0;
                        match_d = 8'd0;
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                VERIFY: begin
                    s_d = {s_q[28:0], bit_in};
                    if (bit_in == pred) begin
                        match_d = match_q + 8'd1;
                        if (match_d == LOCK_C) begin
                            state_d = LOCKED;
                            win_d   = 16'd0;
                            bad_d   = 8'd0;
                        end
                    end else begin
                        // The mismatching bit becomes the first seed bit.
                        state_d = SEED;
                        fill_d  = 5'd1;
                    end
                end
                LOCKED: begin
                    // Flywheel: shift in the prediction so that one corrupted bit causes only one error.
                    s_d = {s_q[28:0], pred};
                    err = (bit_in != pred);
                    if (err) begin
                        pulse_d = 1'b1;
                        bad_inc = bad_q + 8'd1;
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    end
                    if (err && bad_inc == ERR_C) begin
                        state_d = SEED;
                        fill_d  = 5'd0;
                    end
                    if (win_inc == WIN_C) begin
                        win_d = 16'd0;
                        bad_d = 8'd0;
                    end else begin
                        win_d = win_inc;
                        bad_d = bad_inc;
                    end
                end
                default: state_d = SEED;
            endcase
        end
        if (err_clr) cnt_d = 16'd0;
        lock_d = (state_d == LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
            s_q     <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            bad_q   <= '0;
            lock_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            bad_q   <= bad_d;
            lock_q  <= lock_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lock      = lock_q;
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed test of lfsr_checker that drives it from a reference LFSR generator
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        lock;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;

    int n_assert = 0;
    int n_fail   = 0;
    logic [29:0] g = 30'hA;

    lfsr_checker #(.LOCK_COUNT(16), .ERR_LIMIT(4), .WINDOW(64)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .err_clr(err_clr),
        .lock(lock), .err_pulse(err_pulse), .err_count(err_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the next generator bit (optionally inverted) with bit_valid high.
    task automatic send(input bit flip, input bit clr);
        logic b;
        @(negedge clk);
        b = g[29] ^ g[5] ^ g[3] ^ g[0];
        g = {g[28:0], b};
        bit_in    = b ^ flip;
        bit_valid = 1'b1;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit clr);
        @(negedge clk);
        bit_valid = 1'b0;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bit_valid = 1'b0;
        err_clr   = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnt", 32'(err_count), 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);

        // Clean stream: VERIFY after 30 bits, lock after 46
        for (int i = 1; i <= 46; i++) begin
            send(1'b0, 1'b0);
            chk("clean_pulse", 32'(err_pulse), 32'd0);
            if (i == 30) chk("verify_state", 32'(state), 32'd1);
            if (i == 45) chk("lock_45", 32'(lock), 32'd0);
        end
        chk("lock_46", 32'(lock), 32'd1);
        chk("lock_state", 32'(state), 32'd2);
        chk("clean_cnt", 32'(err_count), 32'd0);

        // A single flipped bit gives exactly one error
        send(1'b1, 1'b0);
        chk("flip1_pulse", 32'(err_pulse), 32'd1);
        chk("flip1_cnt", 32'(err_count), 32'd1);
        chk("flip1_lock", 32'(lock), 32'd1);
        for (int i = 0; i < 63; i++) begin
            send(1'b0, 1'b0);
            chk("after_flip_pulse", 32'(err_pulse), 32'd0);
        end
        chk("after_flip_cnt", 32'(err_count), 32'd1);
        chk("after_flip_lock", 32'(lock), 32'd1);

        // Clear while idle
        idle(1'b1);
        chk("clr_cnt", 32'(err_count), 32'd0);
        chk("idle_pulse", 32'(err_pulse), 32'd0);

        // Four errors in one window drop lock with the 4th pulse
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("e3_lock", 32'(lock), 32'd1);
        chk("e3_pulse", 32'(err_pulse), 32'd1);
        send(1'b1, 1'b0);
        chk("e4_pulse", 32'(err_pulse), 32'd1);
        chk("e4_lock", 32'(lock), 32'd0);
        chk("e4_state", 32'(state), 32'd0);
        chk("e4_cnt", 32'(err_count), 32'd4);
        for (int i = 1; i <= 46; i++) begin
            send(1'b0, 1'b0);
            chk("relock_pulse", 32'(err_pulse), 32'd0);
            if (i == 45) chk("relock_45", 32'(lock), 32'd0);
        end
        chk("relock_46", 32'(lock), 32'd1);
        chk("relock_cnt", 32'(err_count), 32'd4);

        // Three errors at the end of one window and three at the start of the next: lock held
        idle(1'b1);
        for (int i = 0; i < 128; i++) begin
            send((i >= 61 && i <= 66) ? 1'b1 : 1'b0, 1'b0);
            chk("win_lock", 32'(lock), 32'd1);
        end
        chk("win_cnt", 32'(err_count), 32'd6);
        chk("win_state", 32'(state), 32'd2);

        // Asynchronous reset while locked, with no clock edge
        #2;
        rst = 1'b1;
        #2;
        chk("arst_lock", 32'(lock), 32'd0);
        chk("arst_cnt", 32'(err_count), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // A mismatch in VERIFY returns to SEED silently
        for (int i = 1; i <= 35; i++) send(1'b0, 1'b0);
        chk("v35_state", 32'(state), 32'd1);
        send(1'b1, 1'b0);
        chk("vmis_state", 32'(state), 32'd0);
        chk("vmis_pulse", 32'(err_pulse), 32'd0);
        chk("vmis_cnt", 32'(err_count), 32'd0);
        do_reset();

        // bit_valid every other cycle
        for (int i = 1; i <= 46; i++) begin
            send(1'b0, 1'b0);
            if (i == 45) chk("half_lock_45", 32'(lock), 32'd0);
            idle(1'b0);
            if (i == 30) chk("half_hold_state", 32'(state), 32'd1);
        end
        chk("half_lock_46", 32'(lock), 32'd1);
        send(1'b1, 1'b0);
        chk("half_e1_cnt", 32'(err_count), 32'd1);
        idle(1'b0);
        chk("half_idle_pulse", 32'(err_pulse), 32'd0);
        chk("half_idle_cnt", 32'(err_count), 32'd1);
        // err_clr coincident with an error
        send(1'b1, 1'b1);
        chk("clr_err_pulse", 32'(err_pulse), 32'd1);
        chk("clr_err_cnt", 32'(err_count), 32'd0);
        idle(1'b0);
        chk("clr_after_pulse", 32'(err_pulse), 32'd0);
        chk("clr_after_lock", 32'(lock), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
